ham_dist_pipe: RTL and testbench
================================

// Module: ham_dist_pipe
// PURPOSE
//  Pipelined, parametrised Hamming weight/distance engine with a valid/ready stream interface.
//  Each cycle it accepts one operand pair (A, B).
//  It returns popcount(A) or popcount(A^B) through a registered adder tree.
//  It can also keep a saturating running sum of distances across operations.
//  It is the throughput-oriented successor of the combinational 32-bit weight unit, for the datapath compare/ECC blocks.
// PARAMETERS
//  WIDTH   32  operand width; any value >=2, internally zero-padded to P2 = 2**$clog2(WIDTH)
//  ACC_W   16  accumulator width, >= OUT_W
//  OUT_W   derived, localparam = $clog2(WIDTH+1); result width
//  LEVELS  derived, localparam = $clog2(WIDTH); adder-tree levels
//  LAT     derived, localparam = LEVELS+1; accept-to-output latency in cycles when not stalled
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous, active-low reset
//  in_valid   in   1       operand pair valid
//  in_ready   out  1       block can accept this cycle
//  in_mode    in   2       00 WEIGHT(A), 01 DIST(A^B), 10 ACC (DIST + accumulate), 11 CLR (DIST, acc := result)
//  in_a       in   WIDTH   operand A
//  in_b       in   WIDTH   operand B (ignored in WEIGHT)
//  out_valid  out  1       result valid
//  out_ready  in   1       sink accepts result
//  out_weight out  OUT_W   weight/distance of the operation at the head
//  out_acc    out  ACC_W   accumulator value after this operation is applied
//  out_sat    out  1       sticky accumulator-saturated flag, as of this operation
// BEHAVIOUR
//  - Reset (async, rst_n=0):
//    - all stage valids, out_valid, out_weight, out_acc and out_sat go to 0 immediately.
//    - in-flight operations are dropped.
//    - in_ready = 1 from the first edge after release.
//  - Pipe enable: en = out_ready | ~out_valid, and in_ready = en.
//    - All stages advance together only when en=1; otherwise every stage holds.
//  - Transfer in: in_valid & in_ready.
//  - Stage 0 registers:
//    - X = (mode==WEIGHT) ? A : A^B, zero-padded to P2;
//    - mode; and
//    - valid = in_valid & in_ready.
//  - Stages 1..LEVELS each add adjacent field pairs. Level k fields are k+1 bits wide with no truncation.
//  - The final sum enters the output register (out_weight) at stage LAT.
//  - Latency: a result is visible at out_valid exactly LAT cycles after acceptance, if en stays 1.
//  - Throughput: 1 operation per cycle.
//  - Bubbles travel as valid=0 slots. A bubble never updates the accumulator.
//  - Accumulator updates on the same edge a valid result loads into the output register, in input order:
//    - WEIGHT and DIST: acc unchanged.
//    - ACC: acc := min(acc + result, 2**ACC_W-1). out_sat is set if the sum exceeded the max.
//    - CLR: acc := result and out_sat := 0.
//    - out_acc and out_sat show the post-update values alongside that result.
//  - out_sat is sticky until a CLR operation or reset.
//  - A stalled output (out_valid=1, out_ready=0):
//    - everything holds and outputs stay stable;
//    - in_valid is ignored (in_ready=0).
//  - Simultaneous output drain and input accept in one cycle is legal and loses nothing.
//  - Edge values: a result of 0 (A==B) and the maximum result WIDTH both need OUT_W bits exactly. No wrap is allowed.
//  - in_b is don't-care in WEIGHT mode. X/Z on in_b must not reach out_weight.
// STRUCTURE
//  - Shared include ham_defs.vh holds the mode constants:
//    - HAM_MODE_WEIGHT=2'b00, HAM_MODE_DIST=2'b01, HAM_MODE_ACC=2'b10, HAM_MODE_CLR=2'b11;
//    - the macro for OUT_W.
//  - One sub-module, ham_tree_level #(N_IN, FW):
//    - adds N_IN/2 pairs of FW-bit fields into FW+1-bit fields;
//    - registers them with enable en;
//    - carries a valid bit and a 2-bit mode tag.
//    - It is instantiated LEVELS times from a generate loop.
//  - The top holds stage 0, the output register, the accumulator and the handshake.
// TESTING
//  1. WIDTH=32, WEIGHT, A=FFFFFFFF, out_ready=1 -> out_weight=32 exactly 6 cycles later; A=0 -> 0.
//  2. DIST, A=F0F0F0F0 B=0F0F0F0F -> 32; A=B=12345678 -> 0; A=1 B=0, B=X in WEIGHT -> 1, no X.
//  3. 8 back-to-back ops with out_ready pattern 1,0,1,0,... -> all 8 results in order; no drop or duplicate; outputs stable while stalled.
//  4. ACC_W=6: CLR(dist 5) then ACC(dist 32) x2 -> out_acc 5, 37, 63 with out_sat 0, 0, 1; then CLR(dist 3) -> acc 3, sat 0.
//  5. rst_n low with 3 ops in flight and out_valid=1 -> out_valid=0 and out_acc=0 immediately; after release no stale result appears.
//  6. WIDTH=12 build: WEIGHT A=FFF -> 12 after LAT=5 cycles; DIST A=FFF B=000 -> 12.

Source files
------------

// File: rtl/ham_dist_pipe_pkg.sv
// Shared mode encodings, stage tag payload and width helpers for the Hamming weight/distance pipe.
package ham_dist_pipe_pkg;

  localparam logic [1:0] HAM_MODE_WEIGHT = 2'b00;
  localparam logic [1:0] HAM_MODE_DIST   = 2'b01;
  localparam logic [1:0] HAM_MODE_ACC    = 2'b10;
  localparam logic [1:0] HAM_MODE_CLR    = 2'b11;

  typedef struct packed {
    logic       valid;
    logic [1:0] mode;
  } ham_tag_t;

  function automatic int unsigned ham_out_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  // Width of the packed field vector produced by adder-tree level k.
  function automatic int unsigned ham_lvl_w(input int unsigned p2, input int unsigned k);
    return (p2 >> k) * (k + 1);
  endfunction

  // Bit offset of level k inside the concatenated tree bus (levels 1..k-1 precede it).
  function automatic int unsigned ham_lvl_off(input int unsigned p2, input int unsigned k);
    int unsigned off;
    off = 0;
    for (int unsigned j = 1; j < k; j++) begin
      off += ham_lvl_w(p2, j);
    end
    return off;
  endfunction

endpackage

// File: rtl/ham_tree_level.sv
// One registered adder-tree level: sums adjacent FW-bit field pairs into FW+1-bit fields.
module ham_tree_level
  import ham_dist_pipe_pkg::*;
#(
  parameter int unsigned N_IN = 2,
  parameter int unsigned FW   = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en_i,
  input  ham_tag_t                       tag_i,
  input  logic [N_IN*FW-1:0]             fields_i,
  output ham_tag_t                       tag_o,
  output logic [(N_IN/2)*(FW+1)-1:0]     fields_o
);

  localparam int unsigned N_OUT = N_IN / 2;
  localparam int unsigned OW    = FW + 1;

  logic [N_OUT*OW-1:0] fields_d;
  logic [N_OUT*OW-1:0] fields_q;
  ham_tag_t            tag_q;

  always_comb begin
    fields_d = '0;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      fields_d[i*OW +: OW] = OW'(fields_i[(2*i)*FW +: FW]) + OW'(fields_i[(2*i+1)*FW +: FW]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q    <= '0;
      fields_q <= '0;
    end else if (en_i) begin
      tag_q    <= tag_i;
      fields_q <= fields_d;
    end
  end

  assign tag_o    = tag_q;
  assign fields_o = fields_q;

endmodule

// File: rtl/ham_dist_pipe.sv
// Pipelined Hamming weight/distance engine with valid/ready streams and a saturating accumulator.
module ham_dist_pipe
  import ham_dist_pipe_pkg::*;
#(
  parameter int unsigned  WIDTH = 32,
  parameter int unsigned  ACC_W = 16,
  localparam int unsigned OUT_W = ham_out_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_weight,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_sat
);

  localparam int unsigned LEVELS   = $clog2(WIDTH);
  localparam int unsigned P2       = 1 << LEVELS;
  localparam int unsigned TREE_W   = ham_lvl_off(P2, LEVELS + 1);
  localparam int unsigned LAST_OFF = ham_lvl_off(P2, LEVELS);
  localparam int unsigned SUM_W    = ACC_W + 1;

  logic                    en;
  logic [P2-1:0]           s0_x_d;
  logic [P2-1:0]           s0_x_q;
  ham_tag_t                s0_tag_q;
  ham_tag_t [LEVELS:0]     tag;
  logic [TREE_W-1:0]       tree;
  logic [OUT_W-1:0]        res;
  logic [SUM_W-1:0]        acc_sum;

  logic                    out_valid_d, out_valid_q;
  logic [OUT_W-1:0]        out_weight_d, out_weight_q;
  logic [ACC_W-1:0]        acc_d, acc_q;
  logic                    sat_d, sat_q;

  // Whole pipe advances only when the output slot is empty or being drained.
  assign en       = out_ready | ~out_valid_q;
  assign in_ready = en;

  // WEIGHT selects A alone so in_b never reaches the tree in that mode.
  assign s0_x_d = (in_mode == HAM_MODE_WEIGHT) ? P2'(in_a) : P2'(in_a ^ in_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_x_q   <= '0;
      s0_tag_q <= '0;
    end else if (en) begin
      s0_x_q         <= s0_x_d;
      s0_tag_q.valid <= in_valid;
      s0_tag_q.mode  <= in_mode;
    end
  end

  assign tag[0] = s0_tag_q;

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int unsigned N_IN = P2 >> (k - 1);
    logic [N_IN*k-1:0] lvl_in;

    if (k == 1) begin : g_src_x
      assign lvl_in = s0_x_q;
    end else begin : g_src_tree
      assign lvl_in = tree[ham_lvl_off(P2, k - 1) +: ham_lvl_w(P2, k - 1)];
    end

    ham_tree_level #(
      .N_IN (N_IN),
      .FW   (k)
    ) u_lvl (
      .clk      (clk),
      .rst_n    (rst_n),
      .en_i     (en),
      .tag_i    (tag[k-1]),
      .fields_i (lvl_in),
      .tag_o    (tag[k]),
      .fields_o (tree[ham_lvl_off(P2, k) +: ham_lvl_w(P2, k)])
    );
  end

  assign res     = OUT_W'(tree[LAST_OFF +: LEVELS + 1]);
  assign acc_sum = SUM_W'(acc_q) + SUM_W'(res);

  // Output register and accumulator update together, only for valid results.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_weight_d = out_weight_q;
    acc_d        = acc_q;
    sat_d        = sat_q;
    if (en) begin
      out_valid_d = tag[LEVELS].valid;
      if (tag[LEVELS].valid) begin
        out_weight_d = res;
        case (tag[LEVELS].mode)
          HAM_MODE_ACC: begin
            if (acc_sum[ACC_W]) begin
              acc_d = '1;
              sat_d = 1'b1;
            end else begin
              acc_d = acc_sum[ACC_W-1:0];
            end
          end
          HAM_MODE_CLR: begin
            acc_d = ACC_W'(res);
            sat_d = 1'b0;
          end
          default: begin
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_weight_q <= '0;
      acc_q        <= '0;
      sat_q        <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_weight_q <= out_weight_d;
      acc_q        <= acc_d;
      sat_q        <= sat_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_weight = out_weight_q;
  assign out_acc    = acc_q;
  assign out_sat    = sat_q;

endmodule

// File: tb/tb_ham_dist_pipe.sv
// Directed bench for ham_dist_pipe: a 32-bit instance with a 6-bit accumulator and a 12-bit instance.
module tb_ham_dist_pipe;
  import ham_dist_pipe_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready, out_sat;
  logic [1:0]  in_mode;
  logic [31:0] in_a, in_b;
  logic [5:0]  out_weight, out_acc;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_sat;
  logic [1:0]  s_in_mode;
  logic [11:0] s_in_a, s_in_b;
  logic [3:0]  s_out_weight;
  logic [15:0] s_out_acc;

  int checks   = 0;
  int failures = 0;

  ham_dist_pipe #(.WIDTH(32), .ACC_W(6)) u_dut32 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mode    (in_mode),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_weight (out_weight),
    .out_acc    (out_acc),
    .out_sat    (out_sat)
  );

  ham_dist_pipe #(.WIDTH(12), .ACC_W(16)) u_dut12 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (s_in_valid),
    .in_ready   (s_in_ready),
    .in_mode    (s_in_mode),
    .in_a       (s_in_a),
    .in_b       (s_in_b),
    .out_valid  (s_out_valid),
    .out_ready  (s_out_ready),
    .out_weight (s_out_weight),
    .out_acc    (s_out_acc),
    .out_sat    (s_out_sat)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] a;
    logic [31:0] b;
    bit          bx;
    logic [31:0] exp_w;
    logic [31:0] exp_acc;
    logic [31:0] exp_sat;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drain();
    @(negedge clk);
    in_valid  = 1'b0;
    in_b      = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Single op on the 32-bit instance with out_ready held high; checks latency and results.
  task automatic run_op(input int idx, input vec_t v);
    int cyc;
    bit got;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_mode   = v.mode;
    in_a      = v.a;
    in_b      = v.bx ? 'x : v.b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_b     = '0;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 20) begin
      @(posedge clk);
      cyc++;
      #1;
      got = out_valid;
    end
    check($sformatf("vec%0d_latency", idx), 32'(cyc), 32'd6);
    check($sformatf("vec%0d_weight", idx), 32'(out_weight), v.exp_w);
    check($sformatf("vec%0d_acc", idx), 32'(out_acc), v.exp_acc);
    check($sformatf("vec%0d_sat", idx), 32'(out_sat), v.exp_sat);
  endtask

  task automatic run12(input string nm, input logic [1:0] m, input logic [11:0] a,
                       input logic [11:0] b, input logic [31:0] exp_w);
    int cyc;
    bit got;
    @(negedge clk);
    s_in_valid = 1'b1;
    s_in_mode  = m;
    s_in_a     = a;
    s_in_b     = b;
    @(posedge clk);
    @(negedge clk);
    s_in_valid = 1'b0;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 20) begin
      @(posedge clk);
      cyc++;
      #1;
      got = s_out_valid;
    end
    check({nm, "_latency"}, 32'(cyc), 32'd5);
    check({nm, "_weight"}, 32'(s_out_weight), exp_w);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tx, rx, extra, stale;
    bit held_v;
    logic [5:0] held_w;

    vecs[0]  = '{HAM_MODE_WEIGHT, 32'hFFFFFFFF, 32'h0,        1'b0, 32'd32, 32'd0,  32'd0};
    vecs[1]  = '{HAM_MODE_WEIGHT, 32'h00000000, 32'h0,        1'b0, 32'd0,  32'd0,  32'd0};
    vecs[2]  = '{HAM_MODE_DIST,   32'hF0F0F0F0, 32'h0F0F0F0F, 1'b0, 32'd32, 32'd0,  32'd0};
    vecs[3]  = '{HAM_MODE_DIST,   32'h12345678, 32'h12345678, 1'b0, 32'd0,  32'd0,  32'd0};
    vecs[4]  = '{HAM_MODE_DIST,   32'h00000001, 32'h0,        1'b0, 32'd1,  32'd0,  32'd0};
    vecs[5]  = '{HAM_MODE_WEIGHT, 32'h00000001, 32'h0,        1'b1, 32'd1,  32'd0,  32'd0};
    vecs[6]  = '{HAM_MODE_WEIGHT, 32'h80000001, 32'h0,        1'b0, 32'd2,  32'd0,  32'd0};
    vecs[7]  = '{HAM_MODE_DIST,   32'h0000FFFF, 32'h00FF00FF, 1'b0, 32'd16, 32'd0,  32'd0};
    vecs[8]  = '{HAM_MODE_WEIGHT, 32'h12345678, 32'h0,        1'b0, 32'd13, 32'd0,  32'd0};
    vecs[9]  = '{HAM_MODE_CLR,    32'h0000001F, 32'h0,        1'b0, 32'd5,  32'd5,  32'd0};
    vecs[10] = '{HAM_MODE_ACC,    32'hFFFFFFFF, 32'h0,        1'b0, 32'd32, 32'd37, 32'd0};
    vecs[11] = '{HAM_MODE_ACC,    32'hFFFFFFFF, 32'h0,        1'b0, 32'd32, 32'd63, 32'd1};
    vecs[12] = '{HAM_MODE_WEIGHT, 32'h00000000, 32'h0,        1'b0, 32'd0,  32'd63, 32'd1};
    vecs[13] = '{HAM_MODE_CLR,    32'h00000007, 32'h0,        1'b0, 32'd3,  32'd3,  32'd0};
    vecs[14] = '{HAM_MODE_ACC,    32'h00000003, 32'h0,        1'b0, 32'd2,  32'd5,  32'd0};

    in_valid    = 1'b0;
    in_mode     = HAM_MODE_WEIGHT;
    in_a        = '0;
    in_b        = '0;
    out_ready   = 1'b0;
    s_in_valid  = 1'b0;
    s_in_mode   = HAM_MODE_WEIGHT;
    s_in_a      = '0;
    s_in_b      = '0;
    s_out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_weight", 32'(out_weight), 32'd0);
    check("rst_out_acc", 32'(out_acc), 32'd0);
    check("rst_out_sat", 32'(out_sat), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed single operations, including accumulate and saturation
    for (int i = 0; i < NVEC; i++) begin
      run_op(i, vecs[i]);
    end
    drain();

    // Back-to-back ops with an alternating sink
    tx = 0;
    rx = 0;
    held_v = 1'b0;
    held_w = '0;
    for (int cyc = 0; cyc < 100 && rx < 8; cyc++) begin
      @(negedge clk);
      out_ready = (cyc % 2 == 0);
      if (tx < 8) begin
        in_valid = 1'b1;
        in_mode  = HAM_MODE_WEIGHT;
        in_a     = 32'hFFFFFFFF >> (4 * tx);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (held_v) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_weight", 32'(out_weight), 32'(held_w));
      end
      held_v = out_valid && !out_ready;
      held_w = out_weight;
      if (out_valid && out_ready) begin
        check($sformatf("b2b_res%0d", rx), 32'(out_weight), 32'(32 - 4 * rx));
        rx++;
      end
      if (in_valid && in_ready) tx++;
    end
    check("b2b_count", 32'(rx), 32'd8);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    extra = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    check("b2b_no_dup", 32'(extra), 32'd0);

    // Asynchronous reset with operations in flight
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_mode  = HAM_MODE_CLR;
      in_a     = 32'h0000001F;
      in_b     = 32'h0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int c = 0; c < 20 && !out_valid; c++) @(negedge clk);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    check("pre_rst_acc", 32'(out_acc), 32'd5);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_weight", 32'(out_weight), 32'd0);
    check("async_rst_acc", 32'(out_acc), 32'd0);
    check("async_rst_sat", 32'(out_sat), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    stale = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("post_rst_no_stale", 32'(stale), 32'd0);

    // 12-bit instance: padded tree, latency 5
    run12("w12_fff", HAM_MODE_WEIGHT, 12'hFFF, 12'h000, 32'd12);
    run12("d12_fff", HAM_MODE_DIST, 12'hFFF, 12'h000, 32'd12);
    run12("d12_eq", HAM_MODE_DIST, 12'hA5C, 12'hA5C, 32'd0);
    run12("w12_801", HAM_MODE_WEIGHT, 12'h801, 12'hFFF, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
